// File: rtl/psram_arbiter.sv
// Two-port arbiter and sequencer in front of the async PSRAM controller.
// Grants one requester, pulses the controller enable, tracks busy and returns ack/rdata.
module psram_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_bank,
    input  logic [21:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_bank,
    input  logic [21:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        ctrl_bank_sel,
    output logic [21:0] ctrl_addr,
    output logic [15:0] ctrl_data_in,
    output logic        ctrl_write_en,
    output logic        ctrl_read_en,
    input  logic        ctrl_busy,
    input  logic        ctrl_read_avail,
    input  logic [15:0] ctrl_data_out,
    output logic        owner_b,
    output logic        timeout_err
);
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          last_grant, last_grant_nx;
    logic          is_write, is_write_nx;
    logic          owner_b_nx, bank_nx, wen_nx, ren_nx;
    logic          a_ack_nx, b_ack_nx, terr_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] din_nx, a_rdata_nx, b_rdata_nx, rdata_ret;
    logic          pick_b, finish, abort;

    // Read-avail coincides with busy falling, so completion is keyed off busy alone.
    logic unused_read_avail;
    assign unused_read_avail = ctrl_read_avail;

    assign pick_b = b_req & (~a_req | (ROUND_ROBIN & ~last_grant));

    // Next-state and next-output logic
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        is_write_nx   = is_write;
        owner_b_nx    = owner_b;
        bank_nx       = ctrl_bank_sel;
        addr_nx       = ctrl_addr;
        din_nx        = ctrl_data_in;
        wen_nx        = 1'b0;
        ren_nx        = 1'b0;
        a_ack_nx      = 1'b0;
        b_ack_nx      = 1'b0;
        a_rdata_nx    = a_rdata;
        b_rdata_nx    = b_rdata;
        terr_nx       = timeout_err;
        finish        = 1'b0;
        abort         = 1'b0;
        cnt_inc       = cnt + CW'(1);

        case (state)
            S_IDLE: begin
                if ((a_req | b_req) && !ctrl_busy) begin
                    bank_nx       = pick_b ? b_bank  : a_bank;
                    addr_nx       = pick_b ? b_addr  : a_addr;
                    din_nx        = pick_b ? b_wdata : a_wdata;
                    is_write_nx   = pick_b ? b_we    : a_we;
                    wen_nx        = is_write_nx;
                    ren_nx        = ~is_write_nx;
                    owner_b_nx    = pick_b;
                    last_grant_nx = pick_b;
                    state_nx      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nx   = '0;
                state_nx = S_WAIT_START;
            end
            S_WAIT_START, S_WAIT_DONE: begin
                cnt_nx = cnt_inc;
                if (state == S_WAIT_DONE && !ctrl_busy) begin
                    finish = 1'b1;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    finish  = 1'b1;
                    abort   = 1'b1;
                    terr_nx = 1'b1;
                end else if (ctrl_busy) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_DONE: begin
                owner_b_nx = 1'b0;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Aborted transactions return zero data regardless of direction
        rdata_ret = abort ? '0 : ctrl_data_out;
        if (finish) begin
            state_nx = S_DONE;
            if (owner_b) begin
                b_ack_nx = 1'b1;
                if (abort || !is_write) b_rdata_nx = rdata_ret;
            end else begin
                a_ack_nx = 1'b1;
                if (abort || !is_write) a_rdata_nx = rdata_ret;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            is_write      <= 1'b0;
            owner_b       <= 1'b0;
            ctrl_bank_sel <= 1'b0;
            ctrl_addr     <= '0;
            ctrl_data_in  <= '0;
            ctrl_write_en <= 1'b0;
            ctrl_read_en  <= 1'b0;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            a_rdata       <= '0;
            b_rdata       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            last_grant    <= last_grant_nx;
            is_write      <= is_write_nx;
            owner_b       <= owner_b_nx;
            ctrl_bank_sel <= bank_nx;
            ctrl_addr     <= addr_nx;
            ctrl_data_in  <= din_nx;
            ctrl_write_en <= wen_nx;
            ctrl_read_en  <= ren_nx;
            a_ack         <= a_ack_nx;
            b_ack         <= b_ack_nx;
            a_rdata       <= a_rdata_nx;
            b_rdata       <= b_rdata_nx;
            timeout_err   <= terr_nx;
        end
    end

endmodule
